// File: rtl/debug_pkg.sv
// Shared debug-stream helpers: ASCII constants, the line-framing FSM encoding and a
// round-robin priority select reused by the debug arbiters.
package debug_pkg;

   localparam int MAX_CH = 16;

   localparam logic [7:0] CHAR_COLON = 8'h3A;
   localparam logic [7:0] CHAR_CR    = 8'h0D;
   localparam logic [7:0] CHAR_LF    = 8'h0A;
   localparam logic [7:0] CHAR_ZERO  = 8'h30;
   localparam logic [7:0] CHAR_A     = 8'h41;

   typedef enum logic [2:0] {IDLE, TAG, COLON, DIGITS, CR, LF} state_t;

   // First set bit strictly after ptr, wrapping within n channels; 0 when none is set.
   function automatic logic [3:0] rr_select(input logic [MAX_CH-1:0] req,
                                            input logic [3:0]        ptr,
                                            input int unsigned       n);
      logic [3:0] g;
      logic       found;
      logic [3:0] idx;
      g     = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= MAX_CH; i++) begin
         idx = 4'((32'(ptr) + i) % n);
         if (i <= n && !found && req[idx]) begin
            g     = idx;
            found = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/ascii_hex_generator.sv
// Serialises a captured value into ASCII hex digits, most significant nibble first,
// advancing one digit per next_digit pulse.
module ascii_hex_generator
   import debug_pkg::*;
#(
   parameter int NumDigits = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   convert,
   input  logic [4*NumDigits-1:0] value,
   input  logic                   next_digit,
   output logic [7:0]             ascii_digit,
   output logic                   digit_valid
);

   logic [4*NumDigits-1:0] shift_reg;
   logic [7:0]             remaining;
   logic [3:0]             nibble;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         remaining <= '0;
      end else if (convert) begin
         remaining <= 8'(NumDigits);
      end else if (next_digit && remaining != 8'd0) begin
         remaining <= remaining - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (convert) begin
         shift_reg <= value;
      end else if (next_digit) begin
         shift_reg <= shift_reg << 4;
      end
   end

   assign nibble      = shift_reg[4*NumDigits-1 -: 4];
   assign digit_valid = (remaining != 8'd0);

   always_comb begin
      if (nibble < 4'd10) begin
         ascii_digit = CHAR_ZERO + {4'b0, nibble};
      end else begin
         ascii_digit = CHAR_A + ({4'b0, nibble} - 8'd10);
      end
   end

endmodule

// File: rtl/hex_report_scheduler.sv
// Round-robin arbiter that shares one hex generator between requesters and frames
// each captured value as "<tag>:<hex digits>\r\n" on a valid/ready byte stream.
module hex_report_scheduler
   import debug_pkg::*;
#(
   parameter int NumChannels = 4,
   parameter int NumDigits   = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NumChannels-1:0]             req,
   input  logic [NumChannels*4*NumDigits-1:0] value,
   output logic [NumChannels-1:0]             ack,
   output logic                               busy,
   output logic [7:0]                         tx_data,
   output logic                               tx_valid,
   input  logic                               tx_ready
);

   localparam int VW = 4 * NumDigits;

   state_t            state, state_nxt;
   logic [3:0]        ptr;
   logic [3:0]        grant;
   logic [7:0]        tag;
   logic [7:0]        dcnt;
   logic [MAX_CH-1:0] req_pad;
   logic              grant_now;
   logic              hs;
   logic              convert;
   logic              next_digit;
   logic [VW-1:0]     sel_value;
   logic [7:0]        ascii_digit;
   logic              digit_valid;

   assign req_pad   = MAX_CH'(req);
   assign grant     = rr_select(req_pad, ptr, NumChannels);
   assign grant_now = (state == IDLE) && (|req) && !reset;
   assign hs        = tx_valid && tx_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (grant_now) state_nxt = TAG;
         TAG:     if (hs) state_nxt = COLON;
         COLON:   if (hs) state_nxt = DIGITS;
         DIGITS:  if (hs && dcnt == 8'd0) state_nxt = CR;
         CR:      if (hs) state_nxt = LF;
         LF:      if (hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx_valid   = (state != IDLE);
      busy       = (state != IDLE);
      convert    = grant_now;
      next_digit = (state == DIGITS) && hs;
      tx_data    = 8'h00;
      unique case (state)
         TAG:     tx_data = tag;
         COLON:   tx_data = CHAR_COLON;
         DIGITS:  tx_data = ascii_digit;
         CR:      tx_data = CHAR_CR;
         LF:      tx_data = CHAR_LF;
         default: tx_data = 8'h00;
      endcase
      ack       = '0;
      sel_value = '0;
      for (int c = 0; c < NumChannels; c++) begin
         ack[c] = grant_now && (grant == 4'(c));
         if (grant == 4'(c)) sel_value = value[c*VW +: VW];
      end
   end

   // Pointer and digit counter move only at grant and on digit handshakes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr  <= 4'(NumChannels - 1);
         dcnt <= '0;
      end else if (grant_now) begin
         ptr  <= grant;
         dcnt <= 8'(NumDigits - 1);
      end else if (next_digit && dcnt != 8'd0) begin
         dcnt <= dcnt - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (grant_now) tag <= CHAR_ZERO + 8'(grant);
   end

   ascii_hex_generator #(.NumDigits(NumDigits)) hex_gen_0 (
      .clk         (clk),
      .reset       (reset),
      .convert     (convert),
      .value       (sel_value),
      .next_digit  (next_digit),
      .ascii_digit (ascii_digit),
      .digit_valid (digit_valid)
   );

   digits_valid_a: assert property (@(posedge clk) disable iff (reset)
      (state == DIGITS) |-> digit_valid);

endmodule

// File: tb/tb_hex_report_scheduler.sv
// Bench for hex_report_scheduler: a 4-channel and a 10-channel instance share one
// byte/ack scoreboard; the monitored instance is chosen with sel.
module tb_hex_report_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ready = 1'b1;
   logic sel = 1'b0;

   logic [3:0]   req4 = '0;
   logic [63:0]  val4 = '0;
   logic [3:0]   ack4;
   logic         busy4, valid4;
   logic [7:0]   data4;

   logic [9:0]   req10 = '0;
   logic [159:0] val10 = '0;
   logic [9:0]   ack10;
   logic         busy10, valid10;
   logic [7:0]   data10;

   hex_report_scheduler #(.NumChannels(4), .NumDigits(4)) dut4 (
      .clk(clk), .reset(rst), .req(req4), .value(val4), .ack(ack4), .busy(busy4),
      .tx_data(data4), .tx_valid(valid4), .tx_ready(ready));

   hex_report_scheduler #(.NumChannels(10), .NumDigits(4)) dut10 (
      .clk(clk), .reset(rst), .req(req10), .value(val10), .ack(ack10), .busy(busy10),
      .tx_data(data10), .tx_valid(valid10), .tx_ready(ready));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        m_valid, m_busy;
   logic [7:0]  m_data;
   logic [15:0] m_ack;
   assign m_valid = sel ? valid10 : valid4;
   assign m_busy  = sel ? busy10 : busy4;
   assign m_data  = sel ? data10 : data4;
   assign m_ack   = sel ? 16'(ack10) : 16'(ack4);

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q[$];
   int         ack_q[$];
   bit         mon_en = 1'b0;
   int         hs_n = 0, first_hs = 0, last_hs = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: got %0h expected nothing (cycle %0d)", nm, act, cyc);
   endtask

   function automatic logic [7:0] hexc(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h37 + {4'b0, n});
   endfunction

   task automatic expect_line(input int ch, input logic [15:0] v);
      logic [15:0] t;
      t = v;
      ack_q.push_back(ch);
      exp_q.push_back(8'h30 + 8'(ch));
      exp_q.push_back(8'h3A);
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(hexc(t[15:12]));
         t = t << 4;
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   // Monitor: pops the scoreboard on acks and byte handshakes, checks stall stability.
   initial begin
      bit         stalled;
      logic [7:0] held;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (stalled) begin
               chk("hold_valid", 32'(m_valid), 32'd1);
               chk("hold_data", 32'(m_data), 32'(held));
            end
            if (m_ack != 16'd0) begin
               if (ack_q.size() == 0) fail_now("ack_unexpected", 32'(m_ack));
               else chk("ack", 32'(m_ack), 32'(16'd1 << ack_q.pop_front()));
            end
            if (m_valid && ready) begin
               if (exp_q.size() == 0) fail_now("byte_unexpected", 32'(m_data));
               else chk("byte", 32'(m_data), 32'(exp_q.pop_front()));
               if (hs_n == 0) first_hs = cyc;
               last_hs = cyc;
               hs_n++;
            end
            stalled = m_valid && !ready;
            held    = m_data;
         end else begin
            stalled = 1'b0;
         end
      end
   end

   // Runs until the scoreboard drains and the DUT is idle. drop_after=0: each requester
   // drops on its own ack; otherwise all requests drop once that many acks were seen.
   task automatic run(input int max_cyc, input bit stall, input int drop_after, input bit chg);
      bit          pat[5];
      logic [15:0] pend;
      int          acks;
      int          n;
      pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      acks = 0;
      n    = 0;
      ready = 1'b1;
      forever begin
         @(negedge clk);
         #1;
         pend = m_ack;
         if (pend != 16'd0) acks++;
         if (exp_q.size() == 0 && ack_q.size() == 0 && !m_busy && pend == 16'd0) break;
         if (n == max_cyc) begin
            fail_now("timeout", 32'(exp_q.size()));
            break;
         end
         n++;
         @(posedge clk);
         #1;
         ready = stall ? pat[n % 5] : 1'b1;
         if (drop_after == 0) begin
            if (sel) req10 = req10 & ~pend[9:0];
            else     req4  = req4 & ~pend[3:0];
         end else if (acks >= drop_after) begin
            req4  = '0;
            req10 = '0;
         end
         if (chg && pend != 16'd0) val4[16 +: 16] = 16'h1234;
      end
      exp_q.delete();
      ack_q.delete();
      ready = 1'b1;
      chk("busy_end", 32'(m_busy), 32'd0);
   endtask

   typedef struct {
      int          ch;
      logic [15:0] val;
      bit          stall;
      bit          d10;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [15:0] pend;
      vecs[0] = '{ch: 0, val: 16'h1A2F, stall: 1'b0, d10: 1'b0};
      vecs[1] = '{ch: 0, val: 16'h1A2F, stall: 1'b1, d10: 1'b0};
      vecs[2] = '{ch: 3, val: 16'h0000, stall: 1'b0, d10: 1'b0};
      vecs[3] = '{ch: 2, val: 16'hC0DE, stall: 1'b1, d10: 1'b0};
      vecs[4] = '{ch: 9, val: 16'h00C0, stall: 1'b0, d10: 1'b1};
      vecs[5] = '{ch: 9, val: 16'h00C0, stall: 1'b0, d10: 1'b1};
      vecs[6] = '{ch: 5, val: 16'hFFFF, stall: 1'b1, d10: 1'b1};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid4", 32'(valid4), 32'd0);
      chk("rst_busy4", 32'(busy4), 32'd0);
      chk("rst_data4", 32'(data4), 32'd0);
      chk("rst_ack4", 32'(ack4), 32'd0);
      chk("rst_valid10", 32'(valid10), 32'd0);
      chk("rst_data10", 32'(data10), 32'd0);
      rst    = 1'b0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         sel  = vecs[i].d10;
         hs_n = 0;
         if (vecs[i].d10) begin
            val10[vecs[i].ch*16 +: 16] = vecs[i].val;
            req10[vecs[i].ch] = 1'b1;
         end else begin
            val4[vecs[i].ch*16 +: 16] = vecs[i].val;
            req4[vecs[i].ch] = 1'b1;
         end
         expect_line(vecs[i].ch, vecs[i].val);
         run(200, vecs[i].stall, 0, 1'b0);
         chk("hs_count", 32'(hs_n), 32'd8);
         if (!vecs[i].stall) chk("burst_len", 32'(last_hs - first_hs), 32'd7);
         @(posedge clk);
         #1;
      end

      // Two held requesters alternate; the pointer last granted channel 2.
      sel  = 1'b0;
      val4[0 +: 16]  = 16'h0000;
      val4[32 +: 16] = 16'hFFFF;
      req4 = 4'b0101;
      hs_n = 0;
      expect_line(0, 16'h0000);
      expect_line(2, 16'hFFFF);
      expect_line(0, 16'h0000);
      expect_line(2, 16'hFFFF);
      run(400, 1'b0, 4, 1'b0);
      chk("alt_hs_count", 32'(hs_n), 32'd32);
      @(posedge clk);
      #1;

      // Value captured at grant; a later change must not reach the line.
      val4[16 +: 16] = 16'hBEEF;
      req4 = 4'b0010;
      expect_line(1, 16'hBEEF);
      run(200, 1'b0, 0, 1'b1);
      @(posedge clk);
      #1;

      // Reset mid-message after "3:A" has gone out.
      val4[48 +: 16] = 16'hA5C3;
      req4 = 4'b1000;
      hs_n = 0;
      expect_line(3, 16'hA5C3);
      for (int i = 0; i < 50 && hs_n < 3; i++) begin
         @(negedge clk);
         #1;
         pend = m_ack;
         @(posedge clk);
         #1;
         req4 = req4 & ~pend[3:0];
      end
      chk("pre_rst_sent", 32'(hs_n), 32'd3);
      chk("pre_rst_valid", 32'(valid4), 32'd1);
      mon_en = 1'b0;
      rst    = 1'b1;
      #1;
      chk("async_valid", 32'(valid4), 32'd0);
      chk("async_busy", 32'(busy4), 32'd0);
      chk("async_data", 32'(data4), 32'd0);
      exp_q.delete();
      ack_q.delete();
      val4[0 +: 16]  = 16'h0123;
      val4[48 +: 16] = 16'h3333;
      req4 = 4'b1001;
      @(posedge clk);
      #1;
      chk("rst_hold_ack", 32'(ack4), 32'd0);
      @(posedge clk);
      #1;
      expect_line(0, 16'h0123);
      expect_line(3, 16'h3333);
      hs_n   = 0;
      rst    = 1'b0;
      mon_en = 1'b1;
      run(300, 1'b0, 0, 1'b0);
      chk("post_rst_hs", 32'(hs_n), 32'd16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
